// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational integer ALU between two requesters.
//   Port 0 is the execute stage, port 1 the auxiliary (CSR/debug address) path.
//   Accepted operations are registered into an issue stage that drives the ALU;
//   the ALU result is captured into a tagged response register one cycle later.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_reqN_valid/o_reqN_ready request handshake (N = 0, 1)
//   i_reqN_a/b                operands
//   i_reqN_funct3/funct7_4    ALU op select / sub-or-arith-shift bit
//   i_reqN_imm                immediate form (suppresses subtract)
//   o_alu_a/b/funct3/funct7_4/imm/en   issue stage towards the ALU
//   i_alu_out                 combinational ALU result
//   o_rsp_valid/id/data       response register, i_rsp_ready consumes it

package alu_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3W  = 3;

  // Operation payload carried from the request ports into the issue stage
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [F3W-1:0]  funct3;
    logic            funct7_4;
    logic            imm;
  } alu_op_t;

endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE     = 1,  // 0 = fixed priority, 1 = round-robin
  parameter int unsigned STARVE_LIMIT = 8   // fixed mode: forced port-1 grant, 0 = off
) (
  input  logic            i_clk,
  input  logic            i_rst_n,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic [F3W-1:0]  i_req0_funct3,
  input  logic            i_req0_funct7_4,
  input  logic            i_req0_imm,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req1_b,
  input  logic [F3W-1:0]  i_req1_funct3,
  input  logic            i_req1_funct7_4,
  input  logic            i_req1_imm,

  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [F3W-1:0]  o_alu_funct3,
  output logic            o_alu_funct7_4,
  output logic            o_alu_imm,
  output logic            o_alu_en,
  input  logic [XLEN-1:0] i_alu_out,

  output logic            o_rsp_valid,
  output logic            o_rsp_id,
  output logic [XLEN-1:0] o_rsp_data,
  input  logic            i_rsp_ready
);

  localparam int unsigned SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  // Issue stage
  logic            iss_valid;
  logic            iss_id;
  alu_op_t         iss_op;

  // Response stage
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [XLEN-1:0] rsp_data_q;

  // Arbitration state
  logic            last_grant;
  logic [SCW-1:0]  starve_cnt;

  logic            rsp_adv;
  logic            iss_adv;
  logic            starve_hit;
  logic            starve_sat;
  logic            grant0;
  logic            grant1;
  logic            hs0;
  logic            hs1;
  logic            hs_any;
  alu_op_t         req0_op;
  alu_op_t         req1_op;
  alu_op_t         sel_op;

  assign req0_op = '{a: i_req0_a, b: i_req0_b, funct3: i_req0_funct3,
                     funct7_4: i_req0_funct7_4, imm: i_req0_imm};
  assign req1_op = '{a: i_req1_a, b: i_req1_b, funct3: i_req1_funct3,
                     funct7_4: i_req1_funct7_4, imm: i_req1_imm};

  // Stage advance: a stage may load when it is empty or its content moves on
  assign rsp_adv = !rsp_valid_q || i_rsp_ready;
  assign iss_adv = !iss_valid || rsp_adv;

  // Starvation counter reached its limit (never true when the limit is 0)
  assign starve_sat = (starve_cnt == STARVE_MAX);
  assign starve_hit = (STARVE_LIMIT != 0) && starve_sat;

  // Grant from current request valids; a single requester always wins
  always_comb begin
    grant1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      if (ARB_MODE != 0) grant1 = !last_grant;
      else               grant1 = starve_hit;
    end else begin
      grant1 = i_req1_valid;
    end
    grant0 = i_req0_valid && !grant1;
  end

  // Readies are held low while reset is asserted
  assign o_req0_ready = i_rst_n && iss_adv && grant0;
  assign o_req1_ready = i_rst_n && iss_adv && grant1;

  assign hs0    = i_req0_valid && o_req0_ready;
  assign hs1    = i_req1_valid && o_req1_ready;
  assign hs_any = hs0 || hs1;
  assign sel_op = hs1 ? req1_op : req0_op;

  // Issue register; payload is zeroed when the stage empties so o_alu_* read 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iss_valid <= 1'b0;
      iss_id    <= 1'b0;
      iss_op    <= '0;
    end else if (iss_adv) begin
      iss_valid <= hs_any;
      iss_id    <= hs1;
      iss_op    <= hs_any ? sel_op : '0;
    end
  end

  // Response register; holds while valid and not consumed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rsp_adv) begin
      rsp_valid_q <= iss_valid;
      rsp_id_q    <= iss_valid ? iss_id : 1'b0;
      rsp_data_q  <= iss_valid ? i_alu_out : '0;
    end
  end

  // Last-grant and port-1 starvation tracking, updated only on handshakes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant <= 1'b1;
      starve_cnt <= '0;
    end else begin
      if (hs_any) last_grant <= hs1;
      if (hs1) begin
        starve_cnt <= '0;
      end else if (i_req1_valid && hs0 && !starve_sat) begin
        starve_cnt <= starve_cnt + SCW'(1);
      end
    end
  end

  assign o_alu_a        = iss_op.a;
  assign o_alu_b        = iss_op.b;
  assign o_alu_funct3   = iss_op.funct3;
  assign o_alu_funct7_4 = iss_op.funct7_4;
  assign o_alu_imm      = iss_op.imm;
  assign o_alu_en       = iss_valid;

  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_id       = rsp_id_q;
  assign o_rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance (dut 0) and a fixed-priority
// instance with starvation limit 8 (dut 1) receive the same directed request
// streams; each port holds its payload until accepted.
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        f7;
    logic        imm;
  } op_t;

  typedef struct {
    op_t op;
    int  id;
    int  stage;  // 1 = at the ALU, 2 = waiting in the response slot
    int  acc;
  } fl_t;

  localparam int LIMIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rsp_ready;
  logic rst_nx;
  logic rsp_ready_nx;

  logic        req_valid [2][2];
  op_t         req_op    [2][2];
  logic        ready     [2][2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [2:0]  alu_f3    [2];
  logic        alu_f7    [2];
  logic        alu_imm   [2];
  logic        alu_en    [2];
  logic [31:0] alu_out   [2];
  logic        rsp_valid [2];
  logic        rsp_id    [2];
  logic [31:0] rsp_data  [2];

  // Reference integer ALU (RV32 register/immediate op semantics)
  function automatic logic [31:0] alu_fn(op_t o);
    logic [31:0] r;
    case (o.f3)
      3'd0:    r = (o.f7 && !o.imm) ? o.a - o.b : o.a + o.b;
      3'd1:    r = o.a << o.b[4:0];
      3'd2:    r = {31'd0, $signed(o.a) < $signed(o.b)};
      3'd3:    r = {31'd0, o.a < o.b};
      3'd4:    r = o.a ^ o.b;
      3'd5:    r = o.f7 ? 32'($signed(o.a) >>> o.b[4:0]) : o.a >> o.b[4:0];
      3'd6:    r = o.a | o.b;
      default: r = o.a & o.b;
    endcase
    return r;
  endfunction

  assign alu_out[0] = alu_fn(op_t'({alu_a[0], alu_b[0], alu_f3[0], alu_f7[0], alu_imm[0]}));
  assign alu_out[1] = alu_fn(op_t'({alu_a[1], alu_b[1], alu_f3[1], alu_f7[1], alu_imm[1]}));

  alu_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(LIMIT)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req_valid[0][0]), .o_req0_ready(ready[0][0]),
    .i_req0_a(req_op[0][0].a), .i_req0_b(req_op[0][0].b), .i_req0_funct3(req_op[0][0].f3),
    .i_req0_funct7_4(req_op[0][0].f7), .i_req0_imm(req_op[0][0].imm),
    .i_req1_valid(req_valid[0][1]), .o_req1_ready(ready[0][1]),
    .i_req1_a(req_op[0][1].a), .i_req1_b(req_op[0][1].b), .i_req1_funct3(req_op[0][1].f3),
    .i_req1_funct7_4(req_op[0][1].f7), .i_req1_imm(req_op[0][1].imm),
    .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]), .o_alu_funct3(alu_f3[0]),
    .o_alu_funct7_4(alu_f7[0]), .o_alu_imm(alu_imm[0]), .o_alu_en(alu_en[0]),
    .i_alu_out(alu_out[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_id(rsp_id[0]), .o_rsp_data(rsp_data[0]),
    .i_rsp_ready(rsp_ready)
  );

  alu_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(LIMIT)) u_fx (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req_valid[1][0]), .o_req0_ready(ready[1][0]),
    .i_req0_a(req_op[1][0].a), .i_req0_b(req_op[1][0].b), .i_req0_funct3(req_op[1][0].f3),
    .i_req0_funct7_4(req_op[1][0].f7), .i_req0_imm(req_op[1][0].imm),
    .i_req1_valid(req_valid[1][1]), .o_req1_ready(ready[1][1]),
    .i_req1_a(req_op[1][1].a), .i_req1_b(req_op[1][1].b), .i_req1_funct3(req_op[1][1].f3),
    .i_req1_funct7_4(req_op[1][1].f7), .i_req1_imm(req_op[1][1].imm),
    .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]), .o_alu_funct3(alu_f3[1]),
    .o_alu_funct7_4(alu_f7[1]), .o_alu_imm(alu_imm[1]), .o_alu_en(alu_en[1]),
    .i_alu_out(alu_out[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_id(rsp_id[1]), .o_rsp_data(rsp_data[1]),
    .i_rsp_ready(rsp_ready)
  );

  // Model state: in-flight ops oldest first, pending requests per port, arbitration memory
  fl_t         inf  [2][$];
  op_t         pend [2][2][$];
  int          last_g [2];
  int          lost   [2];
  int          glog  [2][$];
  int          rid   [2][$];
  logic [31:0] rdat  [2][$];
  int          rcyc  [2][$];
  int          rlat  [2][$];

  op_t         tbl     [8];
  logic [31:0] tbl_exp [8];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, d, cyc, got, exp);
    end
  endtask

  function automatic bit rsp_here(int d);
    return inf[d].size() > 0 && inf[d][0].stage == 2;
  endfunction

  function automatic bit iss_here(int d);
    return inf[d].size() > 0 && inf[d][inf[d].size()-1].stage == 1;
  endfunction

  // Which port the arbiter should pick from the currently offered requests
  function automatic int pick(int d);
    bit v0 = req_valid[d][0];
    bit v1 = req_valid[d][1];
    if (v0 && v1) begin
      if (d == 0) return (last_g[d] == 0) ? 1 : 0;
      return (lost[d] >= LIMIT) ? 1 : 0;
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // A new op fits if the ALU slot is empty or its occupant moves on this cycle
  function automatic bit exp_ready(int d, int p);
    bit room = !iss_here(d) || !rsp_here(d) || rsp_ready;
    return rst_n && room && (pick(d) == p);
  endfunction

  task automatic check_dut(int d);
    op_t e;
    if (!rst_n) begin
      chk("rst_ready0", d, 32'(ready[d][0]), 0);
      chk("rst_ready1", d, 32'(ready[d][1]), 0);
      chk("rst_alu_en", d, 32'(alu_en[d]), 0);
      chk("rst_alu_a",  d, alu_a[d], 0);
      chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 0);
      chk("rst_rsp_data",  d, rsp_data[d], 0);
      chk("rst_rsp_id",    d, 32'(rsp_id[d]), 0);
    end else begin
      chk("ready0", d, 32'(ready[d][0]), 32'(exp_ready(d, 0)));
      chk("ready1", d, 32'(ready[d][1]), 32'(exp_ready(d, 1)));
      e = iss_here(d) ? inf[d][inf[d].size()-1].op : '0;
      chk("alu_en", d, 32'(alu_en[d]), 32'(iss_here(d)));
      chk("alu_a",  d, alu_a[d], e.a);
      chk("alu_b",  d, alu_b[d], e.b);
      chk("alu_ctl", d, {27'd0, alu_f3[d], alu_f7[d], alu_imm[d]}, {27'd0, e.f3, e.f7, e.imm});
      chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(rsp_here(d)));
      if (rsp_here(d)) begin
        chk("rsp_data", d, rsp_data[d], alu_fn(inf[d][0].op));
        chk("rsp_id",   d, 32'(rsp_id[d]), 32'(inf[d][0].id));
      end
    end
  endtask

  task automatic advance(int d);
    fl_t e;
    int  g;
    bit  emit, moves, hs;
    g     = pick(d);
    hs    = (g >= 0) && exp_ready(d, g);
    emit  = rsp_here(d) && rsp_ready;
    moves = iss_here(d) && (!rsp_here(d) || rsp_ready);
    if (emit) begin
      e = inf[d].pop_front();
      rid[d].push_back(e.id);
      rdat[d].push_back(alu_fn(e.op));
      rcyc[d].push_back(cyc);
      rlat[d].push_back(cyc - e.acc);
    end
    if (moves) begin
      e = inf[d].pop_back();
      e.stage = 2;
      inf[d].push_back(e);
    end
    if (hs) begin
      e.op    = pend[d][g].pop_front();
      e.id    = g;
      e.stage = 1;
      e.acc   = cyc;
      inf[d].push_back(e);
      glog[d].push_back(g);
      if (g == 1) lost[d] = 0;
      else if (req_valid[d][1] && lost[d] < LIMIT) lost[d]++;
      last_g[d] = g;
    end
  endtask

  // One clock: drive at the falling edge, check and step the model 1 ns later
  task automatic step();
    @(negedge clk);
    rst_n     = rst_nx;
    rsp_ready = rsp_ready_nx;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        inf[d].delete();
        pend[d][0].delete();
        pend[d][1].delete();
        last_g[d] = 1;
        lost[d]   = 0;
      end
      for (int p = 0; p < 2; p++) begin
        req_valid[d][p] = rst_n && pend[d][p].size() > 0;
        req_op[d][p]    = req_valid[d][p] ? pend[d][p][0] : '0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_dut(d);
      if (rst_n) advance(d);
    end
    cyc++;
  endtask

  task automatic push_both(int p, op_t o);
    pend[0][p].push_back(o);
    pend[1][p].push_back(o);
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      glog[d].delete(); rid[d].delete(); rdat[d].delete();
      rcyc[d].delete(); rlat[d].delete();
    end
  endtask

  function automatic bit busy();
    bit b = 0;
    for (int d = 0; d < 2; d++)
      b |= inf[d].size() > 0 || pend[d][0].size() > 0 || pend[d][1].size() > 0;
    return b;
  endfunction

  task automatic drain(string nm);
    int n = 0;
    while (busy() && n < 300) begin
      step();
      n++;
    end
    chk(nm, 0, 32'(busy()), 0);
    step();
  endtask

  task automatic do_reset();
    rst_nx = 1'b0;
    step();
    step();
    rst_nx = 1'b1;
    step();
  endtask

  int          exp_fx [10];
  logic [31:0] hold_d [2];
  logic        hold_i [2];

  initial begin
    tbl[0] = '{a: 32'd5,          b: 32'd3,      f3: 3'd0, f7: 1'b1, imm: 1'b0}; tbl_exp[0] = 32'd2;
    tbl[1] = '{a: 32'h8000_0000,  b: 32'd4,      f3: 3'd5, f7: 1'b1, imm: 1'b1}; tbl_exp[1] = 32'hF800_0000;
    tbl[2] = '{a: 32'h1234_5678,  b: 32'd0,      f3: 3'd1, f7: 1'b0, imm: 1'b1}; tbl_exp[2] = 32'h1234_5678;
    tbl[3] = '{a: 32'd7,          b: 32'd9,      f3: 3'd2, f7: 1'b0, imm: 1'b0}; tbl_exp[3] = 32'd1;
    tbl[4] = '{a: 32'h0000_F0F0,  b: 32'h0FF0,   f3: 3'd4, f7: 1'b0, imm: 1'b0}; tbl_exp[4] = 32'h0000_FF00;
    tbl[5] = '{a: 32'hFFFF_FFFF,  b: 32'd1,      f3: 3'd3, f7: 1'b0, imm: 1'b0}; tbl_exp[5] = 32'd0;
    tbl[6] = '{a: 32'd10,         b: 32'd20,     f3: 3'd0, f7: 1'b1, imm: 1'b1}; tbl_exp[6] = 32'd30;
    tbl[7] = '{a: 32'h8000_0000,  b: 32'd4,      f3: 3'd5, f7: 1'b0, imm: 1'b1}; tbl_exp[7] = 32'h0800_0000;
    exp_fx = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    rst_n = 1'b0; rst_nx = 1'b0; rsp_ready = 1'b1; rsp_ready_nx = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        req_valid[d][p] = 1'b0;
        req_op[d][p]    = '0;
      end

    // Reference ALU pinned to hand-computed results
    for (int i = 0; i < 8; i++) chk("ref_alu", i, alu_fn(tbl[i]), tbl_exp[i]);

    step(); step();
    rst_nx = 1'b1;
    step();

    // Single port-0 subtract: 5 - 3 = 2 two cycles after acceptance
    push_both(0, tbl[0]);
    drain("a_drain");
    for (int d = 0; d < 2; d++) begin
      chk("a_rsp_cnt", d, 32'(rid[d].size()), 1);
      if (rid[d].size() > 0) begin
        chk("a_data", d, rdat[d][0], 32'd2);
        chk("a_id",   d, 32'(rid[d][0]), 0);
        chk("a_latency", d, 32'(rlat[d][0]), 2);
      end
    end

    // Both ports continuously valid from reset
    do_reset();
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      push_both(0, tbl[k % 8]);
      push_both(1, tbl[(k + 3) % 8]);
    end
    drain("b_drain");
    chk("b_rr_cnt", 0, 32'(glog[0].size()), 20);
    chk("b_fx_cnt", 1, 32'(glog[1].size()), 20);
    if (glog[0].size() >= 4)
      for (int i = 0; i < 4; i++) chk("b_rr_order", 0, 32'(glog[0][i]), 32'(i % 2));
    if (glog[1].size() >= 10)
      for (int i = 0; i < 10; i++) chk("b_fx_order", 1, 32'(glog[1][i]), 32'(exp_fx[i]));
    if (rcyc[0].size() >= 8)
      for (int i = 0; i < 7; i++) chk("b_rr_back2back", 0, 32'(rcyc[0][i+1] - rcyc[0][i]), 1);
    for (int d = 0; d < 2; d++) chk("b_rsp_cnt", d, 32'(rid[d].size()), 20);

    // Backpressure: fill the pipe, stall the response for 5 cycles, release
    clear_logs();
    rsp_ready_nx = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_both(0, tbl[(k + 1) % 8]);
      push_both(1, tbl[(k + 5) % 8]);
    end
    step(); step(); step();
    for (int d = 0; d < 2; d++) begin
      hold_d[d] = rsp_data[d];
      hold_i[d] = rsp_id[d];
    end
    for (int s = 0; s < 5; s++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        chk("c_hold_data", d, rsp_data[d], hold_d[d]);
        chk("c_hold_id",   d, 32'(rsp_id[d]), 32'(hold_i[d]));
        chk("c_ready_low", d, 32'({ready[d][0], ready[d][1]}), 0);
      end
    end
    rsp_ready_nx = 1'b1;
    drain("c_drain");
    for (int d = 0; d < 2; d++) chk("c_rsp_cnt", d, 32'(rid[d].size()), 8);

    // Port 1 only: arithmetic right shift, then shift-left by zero
    clear_logs();
    pend[0][1].push_back(tbl[1]); pend[0][1].push_back(tbl[2]);
    pend[1][1].push_back(tbl[1]); pend[1][1].push_back(tbl[2]);
    drain("d_drain");
    for (int d = 0; d < 2; d++) begin
      chk("d_rsp_cnt", d, 32'(rid[d].size()), 2);
      if (rid[d].size() >= 2) begin
        chk("d_sra_data", d, rdat[d][0], 32'hF800_0000);
        chk("d_sra_id",   d, 32'(rid[d][0]), 1);
        chk("d_sll_data", d, rdat[d][1], 32'h1234_5678);
        chk("d_sll_id",   d, 32'(rid[d][1]), 1);
      end
    end

    // Reset with two ops in flight: nothing may come out afterwards
    clear_logs();
    rsp_ready_nx = 1'b0;
    for (int k = 0; k < 3; k++) push_both(0, tbl[k + 3]);
    step(); step(); step();
    for (int d = 0; d < 2; d++) chk("e_full", d, 32'({rsp_valid[d], alu_en[d]}), 32'd3);
    rst_nx = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("e_rst_rsp_valid", d, 32'(rsp_valid[d]), 0);
      chk("e_rst_alu_en",    d, 32'(alu_en[d]), 0);
    end
    step();
    rst_nx = 1'b1;
    rsp_ready_nx = 1'b1;
    clear_logs();
    for (int s = 0; s < 6; s++) step();
    for (int d = 0; d < 2; d++) begin
      chk("e_no_stale_rsp",   d, 32'(rid[d].size()), 0);
      chk("e_no_stale_grant", d, 32'(glog[d].size()), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
